// File: rtl/debounce_multicanal.sv
// Multi-channel push-button debouncer: synchroniser, per-channel stability counter and
// press/release pulses. Define DEBOUNCE_AUTO_REPEAT_EN to add per-channel auto-repeat pulses.
module debounce_multicanal #(
    parameter int unsigned              NUM_CANAIS    = 4,
    parameter int unsigned              COUNTER_WIDTH = 16,
    parameter logic [COUNTER_WIDTH-1:0] COUNTER_MAX   = {COUNTER_WIDTH{1'b1}},
    parameter int unsigned              SYNC_STAGES   = 2,
    parameter logic                     RESET_VALUE   = 1'b0,
    parameter int unsigned              REPEAT_DELAY  = 500,
    parameter int unsigned              REPEAT_PERIOD = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic [NUM_CANAIS-1:0] botoesEntrada,
    output logic [NUM_CANAIS-1:0] botoesFiltrados,
    output logic [NUM_CANAIS-1:0] pulsoPressionado,
    output logic [NUM_CANAIS-1:0] pulsoSolto,
    output logic [NUM_CANAIS-1:0] pulsoRepeticao
);

    if (NUM_CANAIS < 1 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_param_check
        $error("debounce_multicanal: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0][NUM_CANAIS-1:0]   sync_q, sync_d;
    logic [NUM_CANAIS-1:0]                    sinc;
    logic [NUM_CANAIS-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CANAIS-1:0]                    filt_q, filt_d;
    logic [NUM_CANAIS-1:0]                    press_q, press_d;
    logic [NUM_CANAIS-1:0]                    solto_q, solto_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], botoesEntrada};
    end

    assign sinc = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the filtered level discards the whole count.
    always_comb begin
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        press_d = '0;
        solto_d = '0;
        if (habilita) begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                if (sinc[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] < COUNTER_MAX) begin
                    cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
                end else begin
                    cnt_d[i]   = '0;
                    filt_d[i]  = sinc[i];
                    press_d[i] = sinc[i];
                    solto_d[i] = ~sinc[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{{NUM_CANAIS{RESET_VALUE}}}};
            cnt_q   <= '0;
            filt_q  <= {NUM_CANAIS{RESET_VALUE}};
            press_q <= '0;
            solto_q <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            press_q <= press_d;
            solto_q <= solto_d;
        end
    end

    assign botoesFiltrados  = filt_q;
    assign pulsoPressionado = press_q;
    assign pulsoSolto       = solto_q;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [NUM_CANAIS-1:0][RepW-1:0] rep_q, rep_d;
    logic [NUM_CANAIS-1:0]           rpt_q, rpt_d;

    // After the first delay the count cycles DELAY+1..DELAY+PERIOD, so it never overflows.
    always_comb begin
        rep_d = rep_q;
        rpt_d = '0;
        if (habilita) begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                if (!(filt_q[i] && filt_d[i])) begin
                    rep_d[i] = '0;
                end else begin
                    rep_d[i] = rep_q[i] + RepW'(1);
                    if (rep_d[i] == RepW'(REPEAT_DELAY)) begin
                        rpt_d[i] = 1'b1;
                    end else if (rep_d[i] == RepW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
                        rpt_d[i] = 1'b1;
                        rep_d[i] = RepW'(REPEAT_DELAY);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_q <= '0;
            rpt_q <= '0;
        end else begin
            rep_q <= rep_d;
            rpt_q <= rpt_d;
        end
    end

    assign pulsoRepeticao = rpt_q;
`else
    assign pulsoRepeticao = '0;
`endif

endmodule

// File: tb/tb_debounce_multicanal.sv
// Scoreboard bench for debounce_multicanal: stimulus queues expected pulse events and
// snapshots; a negedge monitor pops and compares them. Honors DEBOUNCE_AUTO_REPEAT_EN.
module tb_debounce_multicanal;

    localparam int unsigned DLY = 5;
    localparam int unsigned PER = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoesEntrada;
    logic [3:0] filt, press, solto, rpt;

    debounce_multicanal #(
        .NUM_CANAIS   (4),
        .COUNTER_WIDTH(16),
        .COUNTER_MAX  (16'd7),
        .SYNC_STAGES  (2),
        .RESET_VALUE  (1'b0),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .botoesEntrada   (botoesEntrada),
        .botoesFiltrados (filt),
        .pulsoPressionado(press),
        .pulsoSolto      (solto),
        .pulsoRepeticao  (rpt)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int         e;
        logic [3:0] f;
        logic [3:0] p;
        logic [3:0] s;
        logic [3:0] r;
    } exp_t;

    exp_t ev_q[$];
    exp_t snap_q[$];
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    bit   checked = 1'b0;

    function automatic void push_ev(int e, logic [3:0] f, logic [3:0] p, logic [3:0] s,
                                    logic [3:0] r);
        ev_q.push_back('{e, f, p, s, r});
    endfunction

    function automatic void push_snap(int e, logic [3:0] f);
        snap_q.push_back('{e, f, 4'b0, 4'b0, 4'b0});
    endfunction

    // One press at edge pe and release at edge re on channels m, others idle at 0.
    function automatic void push_cycle(logic [3:0] m, int pe, int re);
        push_ev(pe, m, m, 4'b0, 4'b0);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        for (int k = pe + DLY; k < re; k += PER) push_ev(k, m, 4'b0, 4'b0, m);
`endif
        push_ev(re, 4'b0, 4'b0, m, 4'b0);
    endfunction

    function automatic void chk(string nm, int e, logic [3:0] act, logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", nm, e, act, want);
        end
    endfunction

    always @(negedge clock) begin
        exp_t x;
        while (snap_q.size() > 0 && snap_q[0].e < edge_n) begin
            total++;
            bad++;
            $display("FAIL snap_missed edge=%0d got=none want=checked", snap_q[0].e);
            void'(snap_q.pop_front());
        end
        if (snap_q.size() > 0 && snap_q[0].e == edge_n) begin
            x = snap_q.pop_front();
            chk("snap_filt", edge_n, filt, x.f);
            chk("snap_press", edge_n, press, x.p);
            chk("snap_solto", edge_n, solto, x.s);
            chk("snap_rpt", edge_n, rpt, x.r);
        end
        while (ev_q.size() > 0 && ev_q[0].e < edge_n) begin
            total++;
            bad++;
            $display("FAIL event_missing edge=%0d got=no_pulse want=f%b p%b s%b r%b",
                     ev_q[0].e, ev_q[0].f, ev_q[0].p, ev_q[0].s, ev_q[0].r);
            void'(ev_q.pop_front());
        end
        if (|{press, solto, rpt}) begin
            if (ev_q.size() > 0 && ev_q[0].e == edge_n) begin
                x = ev_q.pop_front();
                chk("ev_filt", edge_n, filt, x.f);
                chk("ev_press", edge_n, press, x.p);
                chk("ev_solto", edge_n, solto, x.s);
                chk("ev_rpt", edge_n, rpt, x.r);
            end else begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse edge=%0d got=p%b s%b r%b want=none",
                         edge_n, press, solto, rpt);
            end
        end
        if (done && !checked) begin
            total++;
            if (ev_q.size() + snap_q.size() != 0) begin
                bad++;
                $display("FAIL leftover got=%0d want=0", ev_q.size() + snap_q.size());
            end
            checked = 1'b1;
        end
    end

    task automatic go_to(input int e);
        while (edge_n < e) @(negedge clock);
    endtask

    initial begin
        automatic logic bounce [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                        1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        reset         = 1'b1;
        habilita      = 1'b1;
        botoesEntrada = 4'b1111;

        // Inputs already high through reset: all channels rise 10 edges after release.
        for (int e = 1; e <= 3; e++) push_snap(e, 4'b0);
        push_snap(12, 4'b0);
        push_cycle(4'b1111, 13, 23);
        go_to(3);
        reset = 1'b0;
        go_to(13);
        botoesEntrada = 4'b0000;

        // Clean step on ch0.
        go_to(30);
        push_snap(39, 4'b0000);
        push_snap(41, 4'b0001);
        push_cycle(4'b0001, 40, 60);
        botoesEntrada = 4'b0001;
        go_to(50);
        botoesEntrada = 4'b0000;

        // Bouncing ch1: only the final steady run counts.
        go_to(65);
        push_snap(84, 4'b0000);
        push_cycle(4'b0010, 85, 100);
        for (int j = 0; j < 10; j++) begin
            botoesEntrada = {2'b00, bounce[j], 1'b0};
            @(negedge clock);
        end
        botoesEntrada = 4'b0010;
        go_to(90);
        botoesEntrada = 4'b0000;

        // Ch2 with habilita only every 4th cycle.
        go_to(105);
        push_snap(136, 4'b0000);
        push_snap(138, 4'b0100);
        push_cycle(4'b0100, 137, 147);
        for (int k = 0; k < 32; k++) begin
            botoesEntrada = 4'b0100;
            habilita      = (k % 4 == 3);
            @(negedge clock);
        end
        habilita      = 1'b1;
        botoesEntrada = 4'b0000;

        // Ch3 count interrupted by a one-cycle reset.
        go_to(150);
        botoesEntrada = 4'b1000;
        push_snap(156, 4'b0000);
        push_snap(157, 4'b0000);
        push_cycle(4'b1000, 167, 182);
        go_to(156);
        reset = 1'b1;
        go_to(157);
        reset = 1'b0;
        go_to(172);
        botoesEntrada = 4'b0000;

        go_to(190);
        done = 1'b1;
        for (int i = 0; i < 10 && !checked; i++) @(negedge clock);
        if (!checked) begin
            $display("FAIL final_check got=not_run want=run");
            $fatal(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
